// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: valid/ready instruction-word stream into the boot loader
interface imem_boot_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a program into imem from address 0, then releases the core after a settling delay
module imem_boot_loader #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  imem_boot_loader_if.slave     s,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_reset_n,
  output logic                  boot_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   load_count
);
  typedef enum logic [1:0] {LOAD, HOLD, RUN, ERROR} state_t;
  state_t     st;
  logic [3:0] dly;
  logic       acc;
  assign s.s_ready = st == LOAD;
  assign acc       = s.s_valid && s.s_ready;
  // load_count saturates at DEPTH, so its top bit set means the memory is full
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st           <= LOAD;
      dly          <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_reset_n <= 1'b0;
      boot_done    <= 1'b0;
      load_error   <= 1'b0;
      load_count   <= '0;
    end else begin
      imem_we <= 1'b0;
      case (st)
        LOAD: if (acc) begin
          if (load_count[ADDR_WIDTH]) begin
            st         <= ERROR;
            load_error <= 1'b1;
          end else begin
            imem_we    <= 1'b1;
            imem_addr  <= load_count[ADDR_WIDTH-1:0];
            imem_wdata <= s.s_data;
            load_count <= load_count + 1'b1;
            if (s.s_last) begin
              st  <= HOLD;
              dly <= 4'(RELEASE_DELAY);
            end
          end
        end
        HOLD: if (dly == 4'd1) begin
          st           <= RUN;
          core_reset_n <= 1'b1;
          boot_done    <= 1'b1;
        end else begin
          dly <= dly - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: random and directed loads on a 256-word and a 4-word loader against an event-level model
module tb_imem_boot_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic        va [2];
  logic [31:0] da [2];
  logic        la [2];
  imem_boot_loader_if #(.DATA_WIDTH(32)) if0 ();
  imem_boot_loader_if #(.DATA_WIDTH(32)) if1 ();
  assign if0.s_valid = va[0];
  assign if0.s_data  = da[0];
  assign if0.s_last  = la[0];
  assign if1.s_valid = va[1];
  assign if1.s_data  = da[1];
  assign if1.s_last  = la[1];
  logic        we0, we1, crn0, crn1, bd0, bd1, le0, le1;
  logic [7:0]  a0;
  logic [1:0]  a1;
  logic [31:0] wd0, wd1;
  logic [8:0]  c0;
  logic [2:0]  c1;
  imem_boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RELEASE_DELAY(4)) dut0 (
    .clk(clk), .reset_n(rst_n), .s(if0.slave), .imem_we(we0), .imem_addr(a0),
    .imem_wdata(wd0), .core_reset_n(crn0), .boot_done(bd0), .load_error(le0), .load_count(c0));
  imem_boot_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .RELEASE_DELAY(2)) dut1 (
    .clk(clk), .reset_n(rst_n), .s(if1.slave), .imem_we(we1), .imem_addr(a1),
    .imem_wdata(wd1), .core_reset_n(crn1), .boot_done(bd1), .load_error(le1), .load_count(c1));
  int          dep [2] = '{256, 4};
  int          rd  [2] = '{4, 2};
  int          cyc = 0;
  int          n   [2];
  bit          done[2], err[2], we_e[2];
  int          lc  [2];
  logic [7:0]  ad_e[2];
  logic [31:0] wd_e[2];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      n[i] = 0; done[i] = 0; err[i] = 0; we_e[i] = 0; lc[i] = 0; ad_e[i] = 0; wd_e[i] = 0;
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      bit rel;
      rel = done[i] && (cyc - lc[i] >= rd[i]);
      chk($sformatf("ready%0d", i), i ? if1.s_ready : if0.s_ready, !done[i] && !err[i]);
      chk($sformatf("we%0d", i), i ? we1 : we0, we_e[i]);
      chk($sformatf("addr%0d", i), i ? {6'b0, a1} : a0, ad_e[i]);
      chk($sformatf("wdata%0d", i), i ? wd1 : wd0, wd_e[i]);
      chk($sformatf("count%0d", i), i ? {6'b0, c1} : c0, n[i]);
      chk($sformatf("error%0d", i), i ? le1 : le0, err[i]);
      chk($sformatf("boot_done%0d", i), i ? bd1 : bd0, rel);
      chk($sformatf("core_rst_n%0d", i), i ? crn1 : crn0, rel);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        bit acc;
        acc = va[i] && !done[i] && !err[i];
        we_e[i] = 0;
        if (acc) begin
          if (n[i] < dep[i]) begin
            we_e[i] = 1; ad_e[i] = 8'(n[i]); wd_e[i] = da[i]; n[i]++;
            if (la[i]) begin done[i] = 1; lc[i] = cyc; end
          end else err[i] = 1;
        end
      end
    end
    #1 check_all();
  endtask
  task automatic idle(input int k);
    repeat (k) tick();
  endtask
  task automatic send(input int i, input logic [31:0] d, input bit l, input int gaps);
    repeat (gaps) tick();
    va[i] = 1'b1; da[i] = d; la[i] = l;
    tick();
    va[i] = 1'b0; la[i] = 1'b0; da[i] = $urandom;
  endtask
  task automatic pulse_reset();
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk) rst_n = 1'b1;
  endtask
  task automatic prog3(input int gaps);
    send(0, 32'h00500113, 0, 0);
    send(0, 32'h00C00193, 0, gaps);
    send(0, 32'h00300393, 1, gaps);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin va[i] = 0; da[i] = 0; la[i] = 0; end
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    prog3(0);
    idle(6);
    send(0, $urandom, 1, 0);
    idle(1);
    pulse_reset();
    prog3(1);
    idle(6);
    pulse_reset();
    send(0, 32'h00000013, 1, 0);
    idle(5);
    send(0, $urandom, 0, 0);
    send(0, $urandom, 1, 0);
    pulse_reset();
    send(0, 32'h00500113, 0, 0);
    send(0, 32'h00C00193, 0, 0);
    pulse_reset();
    prog3(0);
    idle(6);
    pulse_reset();
    prog3(0);
    idle(3);
    pulse_reset();
    idle(6);
    for (int t = 0; t < 5; t++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int w = 0; w < len; w++) send(0, $urandom, w == len - 1, $urandom_range(0, 2));
      idle(6);
      pulse_reset();
    end
    for (int w = 0; w < 4; w++) send(1, $urandom, 0, 0);
    send(1, $urandom, 1, 0);
    idle(4);
    send(1, $urandom, 0, 0);
    pulse_reset();
    for (int w = 0; w < 4; w++) send(1, $urandom, w == 3, 0);
    idle(4);
    pulse_reset();
    for (int t = 0; t < 8; t++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int w = 0; w < len; w++) send(1, $urandom, w == len - 1, $urandom_range(0, 1));
      idle(4);
      pulse_reset();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time program loader sitting directly upstream of the single-cycle RISC-V core. Accepts instruction words over a valid/ready stream, writes them sequentially into instruction memory from word address 0, and holds the core in reset until the final word is written plus a fixed settling delay. On release the core fetches from PC 0 with the program in place; overflow of the memory locks the loader in an error state with the core still held.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width; depth DEPTH = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, instruction word width
- RELEASE_DELAY, 4, cycles spent in HOLD between last write and core release; legal range 1..15

- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- s_valid  in  1  stream word valid
- s_ready  out  1  loader can accept a word
- s_data  in  DATA_WIDTH  instruction word
- s_last  in  1  marks final word of program; qualified by s_valid
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_WIDTH  word address for write
- imem_wdata  out  DATA_WIDTH  word to write
- core_reset_n  out  1  active-low reset to the core; registered
- boot_done  out  1  high in RUN
- load_error  out  1  high in ERROR (overflow)
- load_count  out  ADDR_WIDTH+1  number of words written so far

## Operation
- Accept = s_valid && s_ready. s_ready is a function of state only: 1 in LOAD, 0 elsewhere; s_data/s_last ignored when not accepted.
- States: LOAD (reset state), HOLD, RUN, ERROR.
- LOAD: on accept with load_count < DEPTH: register imem_we=1, imem_addr=load_count[ADDR_WIDTH-1:0], imem_wdata=s_data; load_count += 1. If s_last also set: go HOLD, load delay counter with RELEASE_DELAY.
- LOAD: on accept with load_count == DEPTH (memory full): no write, load_count unchanged, go ERROR (regardless of s_last).
- Filling exactly DEPTH words with s_last on the last one is legal -> HOLD.
- HOLD: delay counter decrements each cycle; when it would reach 0 go RUN. No writes.
- RUN: core_reset_n=1, boot_done=1; stays until reset. Further s_valid ignored.
- ERROR: load_error=1, core_reset_n=0, s_ready=0; exit only by reset_n.
- Only path out of RUN/ERROR is reset; no reprogramming without reset.

## Timing
- Reset values (async, immediate): state=LOAD, s_ready=1 (after reset deasserts), imem_we=0, imem_addr=0, imem_wdata=0, core_reset_n=0, boot_done=0, load_error=0, load_count=0.
- Word accepted on edge N: imem_we/imem_addr/imem_wdata valid for exactly the cycle after edge N (one-cycle registered latency); load_count updates at edge N.
- Back-to-back accepts supported at one word per cycle; gaps in s_valid produce gaps in imem_we, addresses stay contiguous.
- Last word accepted on edge N: state HOLD from edge N; core_reset_n and boot_done rise at edge N+RELEASE_DELAY, together, registered. Last imem write lands in cycle N..N+1, always before release since RELEASE_DELAY >= 1.
- Overflow beat accepted on edge N: load_error rises at edge N; imem_we low after edge N.
- reset_n asserted mid-LOAD or mid-HOLD: all outputs to reset values immediately; core_reset_n forced 0 asynchronously; load restarts at address 0.

## Test plan
- 3-word program 0x00500113, 0x00C00193, 0x00300393 with s_last on third, s_valid continuous -> imem writes addr 0,1,2 with those words on consecutive cycles; load_count=3; core_reset_n and boot_done rise 4 cycles after last accept.
- Same program with s_valid bubbles (1 idle cycle between words) -> identical addresses/data, imem_we low in gap cycles, release 4 cycles after last accept.
- Single word 0x00000013 with s_last -> one write at addr 0, load_count=1, release after RELEASE_DELAY; subsequent s_valid in RUN -> s_ready=0, no imem_we.
- ADDR_WIDTH=2: 4 words no s_last then 5th word -> writes addr 0..3, 5th not written, load_error=1, load_count=4, core_reset_n stays 0; also 4 words with s_last on 4th -> legal release, load_error=0.
- Reset pulse after 2 of 3 words, then full 3-word reload -> outputs return to reset values during reset; reload writes addr 0,1,2; release normal.
- Reset asserted in HOLD (1 cycle before release) -> core_reset_n never rises; after reset s_ready=1, load_count=0.
